logic_capture_reader: RTL and testbench
=======================================

Name: logic_capture_reader

Overview:
- Drain side of the capture FIFO. Pops 32-bit sample words from the FIFO read port (valid/pop handshake) and serialises them, least-significant byte first, onto an 8-bit valid/accept byte stream toward the host link.
- A transfer is armed with start_i and a word count. done_o pulses when the last byte has been accepted.
- Sits between the capture FIFO output and the host/USB byte interface.

Parameters:
- COUNT_W, 16, width of the word-count input and the remaining-word counter (maximum transfer 2^COUNT_W-1 words).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  begin a transfer; sampled only in IDLE
- abort_i  in  1  cancel the transfer in progress
- count_i  in  COUNT_W  number of 32-bit words to transfer; sampled with start_i
- fifo_data_i  in  32  FIFO read data
- fifo_valid_i  in  1  FIFO read data valid
- fifo_pop_o  out  1  pop/consume the current FIFO word (combinational)
- data_o  out  8  byte stream data (registered)
- valid_o  out  1  byte stream valid (registered)
- accept_i  in  1  byte sink ready
- busy_o  out  1  transfer in progress (state != IDLE)
- done_o  out  1  one-cycle pulse at transfer completion
- remaining_o  out  COUNT_W  words not yet fully sent

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE.
  - data_o=0, valid_o=0, fifo_pop_o=0, busy_o=0, done_o=0, remaining_o=0.
  - Byte index=0, shift register=0.
- States:
  - IDLE: on start_i, load remaining=count_i. If count_i==0, go to FINISH; else go to FETCH.
  - FETCH: fifo_pop_o = fifo_valid_i. When fifo_valid_i=1, latch fifo_data_i into the shift register, byte index=0, go to SEND.
  - SEND: valid_o=1, data_o=shift[7:0].
    - On accept_i: shift right 8 and increment the byte index.
    - On acceptance of byte 3: decrement remaining.
      - If the new remaining==0, go to FINISH.
      - Else if fifo_valid_i=1, assert fifo_pop_o in that cycle, reload the shift register and stay in SEND (back-to-back, no bubble).
      - Else go to FETCH.
  - FINISH: done_o=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - A byte transfers when valid_o & accept_i.
  - data_o is held stable while valid_o=1 and accept_i=0.
  - valid_o never deasserts without acceptance, except on abort or reset.
  - fifo_pop_o is asserted only when fifo_valid_i=1. At most one word is popped per cycle, and never more than count_i words in total.
- Latency and throughput:
  - First byte appears on valid_o 1 cycle after the pop cycle.
  - Sustained rate is 1 byte/cycle when accept_i=1 and the FIFO is non-empty.
- Boundaries:
  - start_i outside IDLE is ignored.
  - start_i and abort_i together in IDLE: abort wins, start is ignored.
  - abort_i in any non-IDLE state: next cycle IDLE, valid_o=0, remaining=0, no done_o. Any partially sent word is discarded; no pop occurs in the abort cycle.
  - count_i = max value (2^COUNT_W-1): remaining does not wrap.
  - An empty FIFO mid-transfer stalls in FETCH indefinitely, with busy_o held at 1.

Optional Feature:
- Macro LOGIC_CAPTURE_READER_HDR_EN.
- Defined: after start_i, a HDR state sends a 4-byte header before the first data word: 0xA5, then count[7:0], count[15:8], and 0x00 (or count[23:16] if COUNT_W>16), using the same handshake. count_i==0 sends the header, then goes to FINISH. abort_i during HDR behaves as above.
- Not defined: the HDR state and its logic are absent; the first byte out is data byte 0.

Decomposition:
- Shared package logic_capture_pkg:
  - state encoding constants: IDLE, HDR, FETCH, SEND, FINISH
  - header magic constant (8'hA5)
  - bytes-per-word constant (4)
- Sub-module logic_capture_reader_ser: 32-to-8 shift/holding register with byte index and last-byte flag. It takes load and advance strobes and outputs the current byte and last.
- The top level keeps the FSM, remaining counter and pop logic.

Test Plan:
- count_i=2, FIFO preloaded with 0x44332211 and 0x88776655, accept_i=1 → bytes 11 22 33 44 55 66 77 88 on consecutive cycles, 2 pops, done_o one pulse after the last byte, busy_o=0 the cycle after.
- count_i=1, word 0xDEADBEEF, accept_i toggling 1,0,0,1,... → each byte is held stable while stalled, order EF BE AD DE, exactly one pop.
- count_i=3, FIFO empty for 10 cycles after word 1 → valid_o=0 and state FETCH during the gap, no pop while fifo_valid_i=0, remaining_o=2 throughout, completion after words 2 and 3 arrive.
- count_i=0 → no pop, no valid_o, done_o pulse 1 cycle after start (with HDR_EN: bytes A5 00 00 00, then done).
- abort_i asserted after byte 1 of word 1 of 4 → valid_o=0 next cycle, busy_o=0, no done_o, total pops=1. A new start_i with count_i=1 then works normally.
- rst_ni asserted low mid-SEND (asynchronous, between clock edges) → all outputs 0 immediately. After release, start_i with count_i=1 transfers a full word correctly.

Source files
------------

// File: rtl/logic_capture_pkg.sv
// rtl/logic_capture_pkg.sv - shared state encoding and constants for the capture FIFO drain
package logic_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        SEND,
        FINISH
    } state_t;

    localparam logic [7:0] HDR_MAGIC      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/logic_capture_reader_ser.sv
// rtl/logic_capture_reader_ser.sv - 32-to-8 shift register, LS byte first, with last-byte flag
module logic_capture_reader_ser
    import logic_capture_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word,
    output logic [7:0]  data,
    output logic        last
);

    localparam int         IDX_W    = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]      shift;
    logic [IDX_W-1:0] idx;

    // load wins over advance so the final byte of one word can hand over to the next word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift <= '0;
            idx   <= '0;
        end else if (load) begin
            shift <= word;
            idx   <= '0;
        end else if (advance) begin
            shift <= {8'h00, shift[31:8]};
            idx   <= idx + 1'b1;
        end
    end

    assign data = shift[7:0];
    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/logic_capture_reader.sv
// rtl/logic_capture_reader.sv - capture FIFO drain to byte stream; LOGIC_CAPTURE_READER_HDR_EN adds a 4-byte header
module logic_capture_reader
    import logic_capture_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [COUNT_W-1:0] count_i,
    input  logic [31:0]        fifo_data_i,
    input  logic               fifo_valid_i,
    output logic               fifo_pop_o,
    output logic [7:0]         data_o,
    output logic               valid_o,
    input  logic               accept_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [COUNT_W-1:0] remaining_o
);

    state_t             state;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] rem_after;
    logic               valid;
    logic               last;
    logic               word_done;
    logic               start_ok;
    logic               pop;
    logic               load;
    logic [31:0]        load_word;

    assign start_ok  = (state == IDLE) && start_i && !abort_i;
    assign word_done = valid && accept_i && last;
    // a header word does not count against the data words still owed
    assign rem_after = (state == SEND) ? remaining - COUNT_W'(1) : remaining;

    always_comb begin
        pop = 1'b0;
        if (!abort_i && fifo_valid_i) begin
            case (state)
                FETCH:     pop = 1'b1;
                HDR, SEND: pop = word_done && (rem_after != '0);
                default:   pop = 1'b0;
            endcase
        end
    end

`ifdef LOGIC_CAPTURE_READER_HDR_EN
    logic [23:0] count_ext;
    assign count_ext = 24'(count_i);
    assign load      = pop || start_ok;
    assign load_word = start_ok ? {count_ext, HDR_MAGIC} : fifo_data_i;
`else
    assign load      = pop;
    assign load_word = fifo_data_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            valid     <= 1'b0;
            remaining <= '0;
        end else if (abort_i && state != IDLE) begin
            state     <= IDLE;
            valid     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        remaining <= count_i;
`ifdef LOGIC_CAPTURE_READER_HDR_EN
                        state     <= HDR;
                        valid     <= 1'b1;
`else
                        state     <= (count_i == '0) ? FINISH : FETCH;
`endif
                    end
                end
                FETCH: begin
                    if (fifo_valid_i) begin
                        state <= SEND;
                        valid <= 1'b1;
                    end
                end
                HDR, SEND: begin
                    if (word_done) begin
                        remaining <= rem_after;
                        if (rem_after == '0) begin
                            state <= FINISH;
                            valid <= 1'b0;
                        end else if (fifo_valid_i) begin
                            state <= SEND;
                        end else begin
                            state <= FETCH;
                            valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic_capture_reader_ser u_ser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load    (load),
        .advance (valid && accept_i),
        .word    (load_word),
        .data    (data_o),
        .last    (last)
    );

    assign fifo_pop_o  = pop;
    assign valid_o     = valid;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == FINISH);
    assign remaining_o = remaining;

endmodule

// File: tb/tb_logic_capture_reader.sv
// tb/tb_logic_capture_reader.sv - randomized self-checking bench for logic_capture_reader
module tb_logic_capture_reader;

    localparam int COUNT_W = 16;
`ifdef LOGIC_CAPTURE_READER_HDR_EN
    localparam int HDR_LEN = 4;
`else
    localparam int HDR_LEN = 0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic               abort_i;
    logic [COUNT_W-1:0] count_i;
    logic [31:0]        fifo_data_i;
    logic               fifo_valid_i;
    logic               fifo_pop_o;
    logic [7:0]         data_o;
    logic               valid_o;
    logic               accept_i;
    logic               busy_o;
    logic               done_o;
    logic [COUNT_W-1:0] remaining_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] preset_q[$];
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];

    logic_capture_reader #(.COUNT_W(COUNT_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .count_i      (count_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_valid_i (fifo_valid_i),
        .fifo_pop_o   (fifo_pop_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .accept_i     (accept_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .remaining_o  (remaining_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // acc_mode < 0 selects the 1,0,0 accept pattern; abort_at/rst_at are byte counts (-1 = off)
    task automatic run_xfer(input int cnt, input int acc_mode, input int avail_pct, input int gap,
                            input int extra, input int abort_at, input int abort_pops, input int rst_at);
        int          nwords, nexp, nbytes, pops, gap_cnt, data_bytes;
        bit          seen_done, gap_started;
        logic        prev_valid, prev_acc;
        logic [7:0]  prev_data;
        logic [31:0] w;
        logic [15:0] c16;

        fifo_q.delete();
        exp_q.delete();
        nwords = (cnt + extra > 16) ? 16 : cnt + extra;
        nexp   = (cnt > 16) ? 16 : cnt;
        for (int i = 0; i < nwords; i++) begin
            w = (i < preset_q.size()) ? preset_q[i] : $urandom;
            fifo_q.push_back(w);
        end
        preset_q.delete();
        c16 = cnt[15:0];
        if (HDR_LEN > 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(c16[7:0]);
            exp_q.push_back(c16[15:8]);
            exp_q.push_back(8'h00);
        end
        for (int i = 0; i < nexp; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(fifo_q[i] >> (8 * b)));

        start_i      = 1'b1;
        count_i      = c16;
        accept_i     = 1'b0;
        fifo_valid_i = 1'b0;
        abort_i      = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("busy_start", busy_o, 1);

        prev_valid = 0; prev_acc = 0; prev_data = 0;
        nbytes = 0; pops = 0; gap_cnt = 0; gap_started = 0; seen_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            data_bytes = (nbytes > HDR_LEN) ? nbytes - HDR_LEN : 0;
            if (done_o) begin
                check_eq("done_bytes", nbytes, 4 * cnt + HDR_LEN);
                check_eq("done_pops", pops, cnt);
                check_eq("exp_drained", exp_q.size(), 0);
                if (cnt == 0 && HDR_LEN == 0) check_eq("done_latency", cyc, 0);
                seen_done = 1;
                break;
            end
            check_eq("remaining", remaining_o, cnt - data_bytes / 4);
            if (prev_valid && !prev_acc) begin
                check_eq("hold_valid", valid_o, 1);
                check_eq("hold_data", data_o, prev_data);
            end
            if (gap_cnt > 0 && data_bytes >= 4) check_eq("gap_idle", valid_o, 0);

            if (abort_at >= 0 && nbytes == abort_at) begin
                abort_i      = 1'b1;
                accept_i     = 1'b0;
                fifo_valid_i = fifo_q.size() > 0;
                fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
                #1;
                check_eq("abort_nopop", fifo_pop_o, 0);
                @(posedge clk_i);
                @(negedge clk_i);
                abort_i      = 1'b0;
                fifo_valid_i = 1'b0;
                check_eq("abort_valid", valid_o, 0);
                check_eq("abort_busy", busy_o, 0);
                check_eq("abort_done", done_o, 0);
                check_eq("abort_rem", remaining_o, 0);
                if (abort_pops >= 0) check_eq("abort_pops", pops, abort_pops);
                @(posedge clk_i);
                @(negedge clk_i);
                check_eq("abort_done2", done_o, 0);
                fifo_q.delete();
                return;
            end
            if (rst_at >= 0 && nbytes == rst_at) begin
                accept_i     = 1'b1;
                fifo_valid_i = fifo_q.size() > 0;
                @(posedge clk_i);
                #2 rst_ni = 1'b0;
                #1;
                check_eq("rst_data", data_o, 0);
                check_eq("rst_valid", valid_o, 0);
                check_eq("rst_pop", fifo_pop_o, 0);
                check_eq("rst_busy", busy_o, 0);
                check_eq("rst_done", done_o, 0);
                check_eq("rst_rem", remaining_o, 0);
                @(negedge clk_i);
                rst_ni       = 1'b1;
                accept_i     = 1'b0;
                fifo_valid_i = 1'b0;
                fifo_q.delete();
                return;
            end

            accept_i = (acc_mode < 0) ? (cyc % 3 == 0) : ($urandom_range(0, 99) < acc_mode);
            if (gap_cnt > 0) gap_cnt--;
            fifo_valid_i = (fifo_q.size() > 0) && (gap_cnt == 0) && ($urandom_range(0, 99) < avail_pct);
            fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : $urandom;
            #1;
            if (fifo_pop_o) begin
                check_eq("pop_valid", fifo_valid_i, 1);
                pops++;
                check_eq("pop_limit", pops <= cnt, 1);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (!gap_started && gap > 0) begin
                    gap_started = 1;
                    gap_cnt     = gap + 1;
                end
            end
            if (valid_o && accept_i) begin
                check_eq("byte_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check_eq("byte", data_o, exp_q.pop_front());
                nbytes++;
            end
            prev_valid = valid_o;
            prev_acc   = accept_i;
            prev_data  = data_o;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        check_eq("done_seen", seen_done, 1);

        accept_i     = 1'b0;
        fifo_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("post_done", done_o, 0);
        check_eq("post_busy", busy_o, 0);
        check_eq("post_valid", valid_o, 0);
        fifo_q.delete();
    endtask

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        count_i      = '0;
        fifo_data_i  = '0;
        fifo_valid_i = 1'b0;
        accept_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("reset_data", data_o, 0);
        check_eq("reset_valid", valid_o, 0);
        check_eq("reset_pop", fifo_pop_o, 0);
        check_eq("reset_busy", busy_o, 0);
        check_eq("reset_done", done_o, 0);
        check_eq("reset_rem", remaining_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        preset_q = '{32'h44332211, 32'h88776655};
        run_xfer(2, 100, 100, 0, 1, -1, -1, -1);
        preset_q = '{32'hDEADBEEF};
        run_xfer(1, -1, 100, 0, 1, -1, -1, -1);
        run_xfer(3, 100, 100, 10, 0, -1, -1, -1);
        run_xfer(0, 100, 100, 0, 2, -1, -1, -1);
        run_xfer(4, 100, 100, 0, 0, HDR_LEN + 2, 1, -1);
        run_xfer(1, 100, 100, 0, 0, -1, -1, -1);
        run_xfer(2, 100, 100, 0, 0, -1, -1, HDR_LEN + 1);
        run_xfer(1, 100, 100, 0, 0, -1, -1, -1);
        run_xfer(65535, 100, 100, 0, 0, HDR_LEN + 6, 2, -1);
        repeat (12)
            run_xfer($urandom_range(0, 6), $urandom_range(30, 100), $urandom_range(30, 100),
                     0, $urandom_range(0, 2), -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
